fft_frame_capture: RTL and testbench
====================================

FFT_FRAME_CAPTURE -- requirements
Module: fft_frame_capture

Interface
REQ-001 Parameter ADDR_W, default 10, bin address width (frame = 2^ADDR_W bins).
REQ-002 Parameter DATA_W, default 18, signed width of each real/imag component.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 read_valid  input  1  FFT output bin valid this cycle.
REQ-006 counter_addr  input  ADDR_W  bin index of current FFT output.
REQ-007 data_real_in  input  DATA_W  signed real part of bin.
REQ-008 data_imag_in  input  DATA_W  signed imaginary part of bin.
REQ-009 rd_en  input  1  consumer read strobe.
REQ-010 rd_addr  input  ADDR_W  consumer bin address.
REQ-011 rd_real / rd_imag  output  DATA_W each  read data from ready bank.
REQ-012 rd_valid  output  1  rd_real/rd_imag valid.
REQ-013 frame_ready  output  1  complete frame held in read bank.
REQ-014 frame_ack  input  1  consumer releases read bank.
REQ-015 overrun  output  1  sticky: completed frame dropped.
REQ-016 seq_err  output  1  sticky: address discontinuity seen.

Function
REQ-017 Two banks of 2^ADDR_W x 2*DATA_W storage SHALL be used, one write bank, one read bank, swapped by a bank-select bit.
REQ-018 Write FSM states SHALL be IDLE, FILL; IDLE->FILL on read_valid with counter_addr==0 (bin 0 written); other bins in IDLE ignored.
REQ-019 In FILL, read_valid with counter_addr == previous+1 SHALL write the bin; any other address SHALL set seq_err, discard the partial frame, and go to IDLE (or restart FILL if that address is 0).
REQ-020 Writing bin 2^ADDR_W-1 SHALL complete the frame and return FSM to IDLE next cycle.
REQ-021 On completion with frame_ready=0, banks SHALL swap and frame_ready SHALL assert the next cycle.
REQ-022 On completion with frame_ready=1 and no frame_ack that cycle, the frame SHALL be dropped, overrun set, banks unchanged.
REQ-023 Completion and frame_ack in the same cycle SHALL swap banks, frame_ready stays 1, no overrun.
REQ-024 frame_ack with no completion SHALL clear frame_ready next cycle; frame_ack while frame_ready=0 ignored.
REQ-025 Reads: rd_en at cycle N SHALL give rd_real/rd_imag of read bank[rd_addr] and rd_valid=1 at N+1; rd_valid=0 otherwise; reads while frame_ready=0 return stale data, still flagged rd_valid.
REQ-026 read_valid deasserted in FILL SHALL hold state (gaps allowed), not an error.

Reset
REQ-027 reset=0 SHALL clear: FSM to IDLE, bank-select 0, frame_ready 0, rd_valid 0, overrun 0, seq_err 0, peak outputs 0; rd_real/rd_imag 0.
REQ-028 Reset mid-FILL SHALL discard the partial frame; storage contents need not be cleared.

Configuration
REQ-029 Macro FFT_PEAK_DETECT_EN defined SHALL add outputs peak_bin (ADDR_W) and peak_mag (DATA_W+1, unsigned).
REQ-030 With macro: per accepted bin k in 1..2^(ADDR_W-1)-1, mag=|re|+|im| (|-2^(DATA_W-1)| = 2^(DATA_W-1), no saturation); running max updates on strictly greater (tie keeps lower bin); DC and upper half excluded.
REQ-031 With macro: running max cleared on FILL entry; on bank swap peak_bin/peak_mag latched for the new read bank; dropped frames do not update them.
REQ-032 Without macro: ports absent, no magnitude logic synthesized.

Structure
REQ-033 Shared package fft_pkg SHALL hold ADDR_W/DATA_W defaults, FSM state encoding, and the bin {imag,real} packing order (imag in MSBs).
REQ-034 Sub-module fft_bank_ram (one simple-dual-port bank, 1-cycle registered read) SHALL be instantiated twice.

Verification
REQ-035 Stream bins 0..1023 with real=k, imag=-k -> frame_ready=1 one cycle after bin 1023; read addr 5 -> rd_real=5, rd_imag=-5 next cycle.
REQ-036 Second full frame without frame_ack -> overrun=1, read bank still holds first frame; frame_ack on completion cycle -> swap, overrun=0.
REQ-037 Jump 0..99 then 200 -> seq_err=1, FSM IDLE, frame_ready stays 0; following clean 0..1023 -> frame_ready=1.
REQ-038 reset=0 at bin 500 -> all outputs zero next cycle; fresh 0..1023 frame captures correctly.
REQ-039 With FFT_PEAK_DETECT_EN: bin 37 = (300,-400), bin 90 = (700,0), rest 0, bin 0 = (5000,0) -> peak_bin=37, peak_mag=700 (tie, lower bin).
REQ-040 read_valid gaps of 3 cycles every bin -> frame captures identically, no seq_err.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_pkg                                                   |
// | Purpose  : Shared defaults, write-FSM state encoding and bin word    |
// |            packing for the FFT frame capture block.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fft_pkg;

    // Default geometry: 1024-bin frames of 18-bit signed components
    localparam int c_ADDR_W_DEFAULT = 10;
    localparam int c_DATA_W_DEFAULT = 18;

    // Write FSM encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_FILL = 1'b1;

    // Stored bin word is {imag, real}: slot s occupies bits [s*DATA_W +: DATA_W]
    localparam int c_REAL_SLOT = 0;
    localparam int c_IMAG_SLOT = 1;

endpackage
`default_nettype wire

// File: rtl/fft_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_bank_ram                                              |
// | Purpose  : One simple-dual-port frame bank, one write port and one   |
// |            read port with a single-cycle registered read.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fft_bank_ram
    import fft_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int WORD_W = 2 * c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [c_DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Storage array: no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; cleared by reset so the read bus starts at zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fft_frame_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fft_frame_capture                                         |
// | Purpose  : Captures streaming FFT output bins into a ping-pong pair  |
// |            of frame banks, hands complete frames to a consumer and   |
// |            flags dropped frames and address discontinuities.         |
// |            Optional macro FFT_PEAK_DETECT_EN adds a peak-bin search  |
// |            over bins 1..N/2-1 with outputs peak_bin / peak_mag.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fft_frame_capture
    import fft_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT,
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_valid,
    input  logic [ADDR_W-1:0] counter_addr,
    input  logic [DATA_W-1:0] data_real_in,
    input  logic [DATA_W-1:0] data_imag_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_real,
    output logic [DATA_W-1:0] rd_imag,
    output logic              rd_valid,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              overrun,
    output logic              seq_err
`ifdef FFT_PEAK_DETECT_EN
    ,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [DATA_W:0]   peak_mag
`endif
);

    localparam int                c_WORD_W   = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] c_LAST_BIN = '1;
    localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_prev_addr;
    logic              r_bank_sel;     // index of the bank currently being written
    logic              r_frame_ready;
    logic              r_overrun;
    logic              r_seq_err;
    logic              r_rd_valid;
    logic              r_rd_bank;      // bank that served the outstanding read

    logic              w_in_seq;
    logic              w_fill_ok;
    logic              w_start;
    logic              w_seq_bad;
    logic              w_wr_en;
    logic              w_complete;
    logic              w_swap;
    logic [c_WORD_W-1:0] w_wr_word;
    logic [c_WORD_W-1:0] w_rdata [2];
    logic [c_WORD_W-1:0] w_rd_word;

    // Classify the incoming bin against the write FSM. Bin 0 always starts a
    // new frame; in FILL the previous address is never all-ones, so bin 0 can
    // never look like an in-sequence bin.
    always_comb begin
        w_in_seq   = (counter_addr == (r_prev_addr + c_ONE));
        w_fill_ok  = read_valid && (r_state == c_ST_FILL) && w_in_seq;
        w_start    = read_valid && (counter_addr == '0) && !w_fill_ok;
        w_seq_bad  = read_valid && (r_state == c_ST_FILL) && !w_in_seq;
        w_wr_en    = w_fill_ok || w_start;
        w_complete = w_fill_ok && (counter_addr == c_LAST_BIN);
        w_swap     = w_complete && (!r_frame_ready || frame_ack);
        w_wr_word  = '0;
        w_wr_word[c_REAL_SLOT*DATA_W +: DATA_W] = data_real_in;
        w_wr_word[c_IMAG_SLOT*DATA_W +: DATA_W] = data_imag_in;
    end

    // Write FSM: track the last accepted bin of the frame being filled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_prev_addr <= '0;
        end else if (w_start) begin
            r_state     <= c_ST_FILL;
            r_prev_addr <= '0;
        end else if (w_fill_ok) begin
            r_prev_addr <= counter_addr;
            r_state     <= w_complete ? c_ST_IDLE : c_ST_FILL;
        end else if (w_seq_bad) begin
            r_state     <= c_ST_IDLE;
        end
    end

    // Frame hand-off: bank swap, ready flag and the sticky error flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bank_sel    <= 1'b0;
            r_frame_ready <= 1'b0;
            r_overrun     <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end
            if (w_swap) begin
                r_bank_sel    <= ~r_bank_sel;
                r_frame_ready <= 1'b1;
            end else if (w_complete) begin
                r_overrun     <= 1'b1;
            end else if (frame_ack) begin
                r_frame_ready <= 1'b0;
            end
        end
    end

    // Read side: remember which bank answered so the output mux follows it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_bank <= ~r_bank_sel;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        fft_bank_ram #(
            .ADDR_W (ADDR_W),
            .WORD_W (c_WORD_W)
        ) u_ram (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_wr_en && (r_bank_sel == 1'(gi))),
            .i_waddr (counter_addr),
            .i_wdata (w_wr_word),
            .i_re    (rd_en && (r_bank_sel != 1'(gi))),
            .i_raddr (rd_addr),
            .o_rdata (w_rdata[gi])
        );
    end

    assign w_rd_word   = r_rd_bank ? w_rdata[1] : w_rdata[0];
    assign rd_real     = w_rd_word[c_REAL_SLOT*DATA_W +: DATA_W];
    assign rd_imag     = w_rd_word[c_IMAG_SLOT*DATA_W +: DATA_W];
    assign rd_valid    = r_rd_valid;
    assign frame_ready = r_frame_ready;
    assign overrun     = r_overrun;
    assign seq_err     = r_seq_err;

`ifdef FFT_PEAK_DETECT_EN
    logic [DATA_W-1:0] w_abs_re;
    logic [DATA_W-1:0] w_abs_im;
    logic [DATA_W:0]   w_mag;
    logic              w_peak_range;
    logic [ADDR_W-1:0] r_run_bin;
    logic [DATA_W:0]   r_run_mag;
    logic [ADDR_W-1:0] r_peak_bin;
    logic [DATA_W:0]   r_peak_mag;

    // L1 magnitude; the two's-complement negate of the most negative value
    // yields 2^(DATA_W-1), which is exact when read as unsigned
    always_comb begin
        w_abs_re     = data_real_in[DATA_W-1] ? (~data_real_in + 1'b1) : data_real_in;
        w_abs_im     = data_imag_in[DATA_W-1] ? (~data_imag_in + 1'b1) : data_imag_in;
        w_mag        = {1'b0, w_abs_re} + {1'b0, w_abs_im};
        w_peak_range = (counter_addr != '0) && !counter_addr[ADDR_W-1];
    end

    // Running maximum over the lower half (DC excluded), latched on bank swap
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_run_bin  <= '0;
            r_run_mag  <= '0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else begin
            if (w_start) begin
                r_run_bin <= '0;
                r_run_mag <= '0;
            end else if (w_fill_ok && w_peak_range && (w_mag > r_run_mag)) begin
                r_run_bin <= counter_addr;
                r_run_mag <= w_mag;
            end
            if (w_swap) begin
                r_peak_bin <= r_run_bin;
                r_peak_mag <= r_run_mag;
            end
        end
    end

    assign peak_bin = r_peak_bin;
    assign peak_mag = r_peak_mag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fft_frame_capture                                      |
// | Purpose  : Self-checking bench for fft_frame_capture: directed frame |
// |            scenarios plus randomized streaming against a frame-level |
// |            reference model.                                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fft_frame_capture;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int NB = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          read_valid = 1'b0;
    logic [AW-1:0] counter_addr = '0;
    logic [DW-1:0] data_real_in = '0;
    logic [DW-1:0] data_imag_in = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          frame_ack = 1'b0;
    wire  [DW-1:0] rd_real;
    wire  [DW-1:0] rd_imag;
    wire           rd_valid;
    wire           frame_ready;
    wire           overrun;
    wire           seq_err;
`ifdef FFT_PEAK_DETECT_EN
    wire  [AW-1:0] peak_bin;
    wire  [DW:0]   peak_mag;
`endif

    fft_frame_capture #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_valid   (read_valid),
        .counter_addr (counter_addr),
        .data_real_in (data_real_in),
        .data_imag_in (data_imag_in),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_real      (rd_real),
        .rd_imag      (rd_imag),
        .rd_valid     (rd_valid),
        .frame_ready  (frame_ready),
        .frame_ack    (frame_ack),
        .overrun      (overrun),
        .seq_err      (seq_err)
`ifdef FFT_PEAK_DETECT_EN
        ,
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    logic [DW-1:0] m_part_re [NB];
    logic [DW-1:0] m_part_im [NB];
    logic [DW-1:0] m_rdy_re  [NB];
    logic [DW-1:0] m_rdy_im  [NB];
    int            m_expect = -1;     // next bin expected, -1 when waiting for bin 0
    bit            m_fr, m_ovr, m_seq, m_rdv, m_rd_cmp, m_rdy_known;
    logic [DW-1:0] m_rd_re, m_rd_im;
`ifdef FFT_PEAK_DETECT_EN
    logic [AW-1:0] m_pk_bin;
    logic [DW:0]   m_pk_mag;

    function automatic longint mag_of(logic [DW-1:0] a, logic [DW-1:0] b);
        longint x = longint'($signed(a));
        longint y = longint'($signed(b));
        return (x < 0 ? -x : x) + (y < 0 ? -y : y);
    endfunction
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit bg_reads = 1'b0;
    bit bg_acks  = 1'b0;

    function automatic logic [63:0] w64(logic [DW-1:0] v);
        return 64'(v);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit done;
        int a;
        if (!reset) begin
            m_expect = -1; m_fr = 0; m_ovr = 0; m_seq = 0; m_rdv = 0;
            m_rd_re = '0; m_rd_im = '0; m_rd_cmp = 1; m_rdy_known = 0;
`ifdef FFT_PEAK_DETECT_EN
            m_pk_bin = '0; m_pk_mag = '0;
`endif
            return;
        end
        done = 0;
        m_rdv = rd_en;
        m_rd_cmp = rd_en && m_rdy_known;
        if (rd_en) begin
            m_rd_re = m_rdy_re[rd_addr];
            m_rd_im = m_rdy_im[rd_addr];
        end
        if (read_valid) begin
            a = int'(counter_addr);
            if (m_expect >= 0 && a == m_expect) begin
                m_part_re[a] = data_real_in; m_part_im[a] = data_imag_in;
                if (a == NB - 1) begin done = 1; m_expect = -1; end
                else m_expect = a + 1;
            end else begin
                if (m_expect >= 0) m_seq = 1;
                if (a == 0) begin
                    m_part_re[0] = data_real_in; m_part_im[0] = data_imag_in;
                    m_expect = 1;
                end else begin
                    m_expect = -1;
                end
            end
        end
        if (done) begin
            if (!m_fr || frame_ack) begin
                m_rdy_re = m_part_re;
                m_rdy_im = m_part_im;
                m_fr = 1;
                m_rdy_known = 1;
`ifdef FFT_PEAK_DETECT_EN
                begin
                    longint best = 0;
                    int     bb = 0;
                    for (int k = 1; k < NB / 2; k++) begin
                        if (mag_of(m_part_re[k], m_part_im[k]) > best) begin
                            best = mag_of(m_part_re[k], m_part_im[k]);
                            bb = k;
                        end
                    end
                    m_pk_bin = AW'(bb);
                    m_pk_mag = (DW + 1)'(best);
                end
`endif
            end else begin
                m_ovr = 1;
            end
        end else if (frame_ack) begin
            m_fr = 0;
        end
    endtask

    task automatic compare_all();
        check("frame_ready", 64'(frame_ready), 64'(m_fr));
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("seq_err", 64'(seq_err), 64'(m_seq));
        check("rd_valid", 64'(rd_valid), 64'(m_rdv));
        if (m_rd_cmp) begin
            check("rd_real", w64(rd_real), w64(m_rd_re));
            check("rd_imag", w64(rd_imag), w64(m_rd_im));
        end
`ifdef FFT_PEAK_DETECT_EN
        check("peak_bin", 64'(peak_bin), 64'(m_pk_bin));
        check("peak_mag", 64'(peak_mag), 64'(m_pk_mag));
`endif
    endtask

    // One clock: optional background traffic, edge, model, then compare
    task automatic step();
        if (bg_reads) begin
            rd_en   = ($urandom_range(0, 3) == 0);
            rd_addr = AW'($urandom);
        end
        if (bg_acks) frame_ack = ($urandom_range(0, 199) == 0);
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic gen(input int kind, input int k, output logic [DW-1:0] re, output logic [DW-1:0] im);
        re = '0; im = '0;
        case (kind)
            0: begin re = DW'(k); im = DW'(-k); end
            1: begin re = DW'(k + 2000); im = DW'(k); end
            2: begin re = DW'($urandom); im = DW'($urandom); end
            default: begin
                if (k == 0)  re = DW'(5000);
                if (k == 37) begin re = DW'(300); im = DW'(-400); end
                if (k == 90) re = DW'(700);
            end
        endcase
    endtask

    task automatic push_bin(input int addr, input logic [DW-1:0] re, input logic [DW-1:0] im);
        read_valid = 1'b1; counter_addr = AW'(addr);
        data_real_in = re; data_imag_in = im;
        step();
        read_valid = 1'b0;
    endtask

    task automatic push_range(input int kind, input int first, input int last,
                              input int gap, input bit ack_last);
        logic [DW-1:0] re, im;
        for (int k = first; k <= last; k++) begin
            gen(kind, k, re, im);
            if (ack_last && k == NB - 1) frame_ack = 1'b1;
            push_bin(k, re, im);
            frame_ack = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic read_at(input int addr);
        rd_en = 1'b1; rd_addr = AW'(addr);
        step();
        rd_en = 1'b0;
    endtask

    task automatic ack_once();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    initial begin
        int c;
        // Reset state
        repeat (3) step();
        reset = 1'b1;
        check("reset frame_ready", 64'(frame_ready), 64'(0));
        check("reset rd_real", w64(rd_real), w64('0));

        // Clean frame real=k imag=-k, ready one cycle after the last bin
        push_range(0, 0, NB - 1, 0, 1'b0);
        check("first frame_ready", 64'(frame_ready), 64'(1));
        read_at(5);
        check("read5 rd_valid", 64'(rd_valid), 64'(1));
        check("read5 rd_real", w64(rd_real), w64(DW'(5)));
        check("read5 rd_imag", w64(rd_imag), w64(DW'(-5)));

        // Ack coinciding with completion swaps without overrun
        push_range(1, 0, NB - 1, 0, 1'b1);
        check("ack-swap overrun", 64'(overrun), 64'(0));
        check("ack-swap frame_ready", 64'(frame_ready), 64'(1));
        read_at(5);
        check("ack-swap rd_real", w64(rd_real), w64(DW'(2005)));

        // Unacknowledged frame is dropped and the read bank is untouched
        push_range(0, 0, NB - 1, 0, 1'b0);
        check("drop overrun", 64'(overrun), 64'(1));
        read_at(7);
        check("drop rd_real", w64(rd_real), w64(DW'(2007)));
        check("drop rd_imag", w64(rd_imag), w64(DW'(7)));

        // Address jump aborts the frame
        reset = 1'b0; step(); reset = 1'b1;
        push_range(0, 0, 99, 0, 1'b0);
        push_bin(200, '0, '0);
        check("jump seq_err", 64'(seq_err), 64'(1));
        check("jump frame_ready", 64'(frame_ready), 64'(0));
        push_range(0, 0, NB - 1, 0, 1'b0);
        check("after jump frame_ready", 64'(frame_ready), 64'(1));
        read_at(3);
        check("after jump rd_real", w64(rd_real), w64(DW'(3)));

        // Reset in the middle of a fill
        push_range(1, 0, 499, 0, 1'b0);
        reset = 1'b0;
        push_bin(500, DW'(2500), DW'(500));
        reset = 1'b1;
        check("midreset frame_ready", 64'(frame_ready), 64'(0));
        check("midreset seq_err", 64'(seq_err), 64'(0));
        check("midreset rd_real", w64(rd_real), w64('0));
        push_range(1, 0, NB - 1, 0, 1'b0);
        read_at(500);
        check("post-reset rd_real", w64(rd_real), w64(DW'(2500)));

        // Input gaps of three cycles between every bin
        ack_once();
        check("ack clears ready", 64'(frame_ready), 64'(0));
        push_range(0, 0, NB - 1, 3, 1'b0);
        check("gaps frame_ready", 64'(frame_ready), 64'(1));
        check("gaps seq_err", 64'(seq_err), 64'(0));
        read_at(9);
        check("gaps rd_imag", w64(rd_imag), w64(DW'(-9)));

`ifdef FFT_PEAK_DETECT_EN
        ack_once();
        push_range(3, 0, NB - 1, 0, 1'b0);
        check("peak_bin literal", 64'(peak_bin), 64'(37));
        check("peak_mag literal", 64'(peak_mag), 64'(700));
`endif

        // Randomized streaming with occasional jumps, random reads/acks, one reset
        bg_reads = 1'b1;
        bg_acks  = 1'b1;
        c = 0;
        for (int i = 0; i < 14000; i++) begin
            reset = (i == 7000) ? 1'b0 : 1'b1;
            read_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1499) == 0) c = $urandom_range(0, NB - 1);
            counter_addr = AW'(c);
            data_real_in = DW'($urandom);
            data_imag_in = DW'($urandom);
            step();
            if (read_valid) c = (c + 1) % NB;
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
